axi4_stream_fifo: RTL and testbench
===================================

Name: axi4_stream_fifo

Overview:
Parametrised AXI4-Stream buffer with DN lanes of DW-bit data, TKEEP and TLAST carried per beat, and configurable power-of-two DEPTH. Sits between any AXI4-Stream source and drain, for example ADC acquisition to DMA, to absorb backpressure bursts. Provides a fill-level output and a synchronous flush. Optionally gates output until a whole packet is stored.

Parameters:
DN, 1, number of lanes per beat.
DW, 16, bits per lane (signed sample data; treated as opaque bits).
DEPTH, 16, beats of storage; power of two, >=2.
CW, $clog2(DEPTH)+1, fill-level counter width (derived; not overridden).

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset; asynchronous, active-low
clr  in  1  synchronous flush, active-high
sti_TDATA  in  DN*DW  source data
sti_TKEEP  in  DN  source keep
sti_TLAST  in  1  source last
sti_TVALID  in  1  source valid
sti_TREADY  out  1  FIFO ready (not full)
sto_TDATA  out  DN*DW  drain data
sto_TKEEP  out  DN  drain keep
sto_TLAST  out  1  drain last
sto_TVALID  out  1  drain valid
sto_TREADY  in  1  drain ready
lvl  out  CW  beats currently stored, 0..DEPTH

Behaviour:
- Reset (ARESETn low, async): write and read pointers at 0, lvl=0, sti_TREADY=0 while in reset and 1 from the first ACLK edge after release; sto_TVALID=0; sto_TDATA/TKEEP/TLAST are don't-care but must not be X-propagated into control.
- Write: beat stored when sti_TVALID & sti_TREADY at the ACLK edge; TDATA, TKEEP and TLAST are stored together as one word of DN*DW+DN+1 bits.
- Read: beat consumed when sto_TVALID & sto_TREADY; sto_* present the head word; first-word fall-through.
- Latency: a beat written into an empty FIFO appears on sto_* with sto_TVALID=1 on the cycle after the write edge (1 cycle). No combinational path from sti to sto.
- sti_TREADY = (lvl != DEPTH), registered. When full, a read in that same cycle does not allow a same-cycle write; sti_TREADY rises the following cycle.
- sto_TVALID = (lvl != 0), subject to packet gating when the optional feature is enabled.
- lvl: +1 on write only, -1 on read only, unchanged on simultaneous write and read. Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty is decided from lvl, not from pointer compare.
- Simultaneous write and read with lvl=1: output continues without a bubble, and the new beat follows on the next cycle.
- sto_TVALID, once asserted, stays high with stable sto_* data until the beat is accepted (AXI rule). The only exception is clr or reset.
- clr=1 at an edge: pointers reset to 0, lvl=0, sto_TVALID=0 the next cycle. Any write or read in that cycle is discarded. clr takes priority over everything except ARESETn.
- Reset asserted mid-stream: all stored data is lost, and outputs take reset values immediately (asynchronously).
- TKEEP and TLAST are passed through unmodified. No validation of TKEEP patterns.

Optional Feature:
Macro AXI4_STREAM_FIFO_PKT_EN.
- Defined (packet mode): an internal counter pkt (CW bits) tracks complete packets stored. It increments when a beat with TLAST=1 is written and decrements when a beat with TLAST=1 is read; it is unchanged when both happen in the same cycle.
  - sto_TVALID = (lvl != 0) & ((pkt != 0) | (lvl == DEPTH) | cut).
  - cut is a flag that sets when the FIFO is full with pkt=0 (oversize packet). It clears when a TLAST beat is read. This forces cut-through and avoids deadlock.
  - clr and reset zero pkt and cut.
- Undefined: no pkt counter or cut flag; sto_TVALID = (lvl != 0).

Test Plan:
- Reset release, idle: lvl=0, sto_TVALID=0, sti_TREADY=1 on the first edge after ARESETn rises.
- Write 0x0001..0x0010 (DEPTH=16) with sto_TREADY=0: lvl=16, sti_TREADY=0 after the 16th beat; a 17th beat is held by the source. Then sto_TREADY=1: data is read out 0x0001..0x0010 in order, one per cycle.
- Continuous sti_TVALID=1 and sto_TREADY=1: throughput of 1 beat/cycle, lvl stays at 1, first output 1 cycle after first input. Also run random stall patterns on both sides and check order plus TKEEP/TLAST against a scoreboard.
- lvl=5 with clr pulsed during a concurrent write and read: lvl=0 and sto_TVALID=0 next cycle; the following write of 0xABCD is output first.
- Packet mode: write 3 beats with TLAST on the 3rd; sto_TVALID stays 0 until the cycle after the 3rd write. Then write a 20-beat packet (DEPTH=16): cut engages at full, the full packet drains, and cut clears after its TLAST is read.
- ARESETn pulsed low asynchronously mid-burst at lvl=7: sto_TVALID=0 and lvl=0 immediately; normal operation resumes after release.

Source files
------------

// File: rtl/axi4_stream_fifo.sv
// First-word fall-through AXI4-Stream buffer carrying TDATA/TKEEP/TLAST per beat, with fill level and flush.
// Optional packet gating (output held until a whole packet is stored) is enabled by AXI4_STREAM_FIFO_PKT_EN.
module axi4_stream_fifo #(
  parameter int DN    = 1,
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             clr,
  input  logic [DN*DW-1:0] sti_TDATA,
  input  logic [DN-1:0]    sti_TKEEP,
  input  logic             sti_TLAST,
  input  logic             sti_TVALID,
  output logic             sti_TREADY,
  output logic [DN*DW-1:0] sto_TDATA,
  output logic [DN-1:0]    sto_TKEEP,
  output logic             sto_TLAST,
  output logic             sto_TVALID,
  input  logic             sto_TREADY,
  output logic [CW-1:0]    lvl
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = DN*DW + DN + 1;
  localparam logic [CW-1:0] LVL_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] LVL_ZERO = '0;

  logic [WW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [WW-1:0] head;
  logic          wr_en;
  logic          rd_en;
  logic [CW-1:0] lvl_nxt;

  // Handshake: a beat moves on an ACLK edge only when VALID and READY are both high;
  // sto_TVALID never drops and sto_* never change until the head beat is taken (clr/reset excepted).
  assign wr_en = sti_TVALID & sti_TREADY;
  assign rd_en = sto_TVALID & sto_TREADY;

  assign head      = mem[rd_ptr];
  assign sto_TDATA = head[DN*DW-1:0];
  assign sto_TKEEP = head[DN*DW +: DN];
  assign sto_TLAST = head[WW-1];

  always_comb begin
    lvl_nxt = lvl;
    if (clr)
      lvl_nxt = LVL_ZERO;
    else if (wr_en && !rd_en)
      lvl_nxt = lvl + CW'(1);
    else if (rd_en && !wr_en)
      lvl_nxt = lvl - CW'(1);
  end

  // Storage carries no reset; control only ever reads slots that were written.
  always_ff @(posedge ACLK) begin
    if (wr_en && !clr)
      mem[wr_ptr] <= {sti_TLAST, sti_TKEEP, sti_TDATA};
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lvl        <= LVL_ZERO;
      sti_TREADY <= 1'b0;
    end else begin
      lvl        <= lvl_nxt;
      sti_TREADY <= (lvl_nxt != LVL_FULL);
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en)
          wr_ptr <= wr_ptr + AW'(1);
        if (rd_en)
          rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

`ifdef AXI4_STREAM_FIFO_PKT_EN
  logic [CW-1:0] pkt;
  logic          cut;
  logic          wr_last;
  logic          rd_last;

  assign wr_last = wr_en & sti_TLAST;
  assign rd_last = rd_en & sto_TLAST;

  // cut lets an oversize packet stream through once it has filled the buffer.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      pkt <= LVL_ZERO;
      cut <= 1'b0;
    end else if (clr) begin
      pkt <= LVL_ZERO;
      cut <= 1'b0;
    end else begin
      if (wr_last && !rd_last)
        pkt <= pkt + CW'(1);
      else if (rd_last && !wr_last)
        pkt <= pkt - CW'(1);
      if (rd_last)
        cut <= 1'b0;
      else if (lvl == LVL_FULL && pkt == LVL_ZERO)
        cut <= 1'b1;
    end
  end

  assign sto_TVALID = (lvl != LVL_ZERO) & ((pkt != LVL_ZERO) | (lvl == LVL_FULL) | cut);
`else
  assign sto_TVALID = (lvl != LVL_ZERO);
`endif

endmodule

// File: tb/tb_axi4_stream_fifo.sv
// Self-checking bench for axi4_stream_fifo: directed scenarios plus randomized stalls
// against a queue-based model of the stream buffer.
module tb_axi4_stream_fifo;

  localparam int DN    = 1;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int WW    = DN*DW + DN + 1;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             clr = 1'b0;
  logic [DN*DW-1:0] sti_tdata = '0;
  logic [DN-1:0]    sti_tkeep = '0;
  logic             sti_tlast = 1'b0;
  logic             sti_tvalid = 1'b0;
  logic             sti_tready;
  logic [DN*DW-1:0] sto_tdata;
  logic [DN-1:0]    sto_tkeep;
  logic             sto_tlast;
  logic             sto_tvalid;
  logic             sto_tready = 1'b0;
  logic [CW-1:0]    lvl;

  int checks = 0;
  int failures = 0;

  // Model: stored beats in order as {last, keep, data}; m_rdy is low until the first edge after reset.
  logic [WW-1:0] exp_q[$];
  bit            m_rdy = 1'b0;
  bit            m_cut = 1'b0;

  axi4_stream_fifo #(.DN(DN), .DW(DW), .DEPTH(DEPTH)) dut (
    .ACLK       (aclk),
    .ARESETn    (aresetn),
    .clr        (clr),
    .sti_TDATA  (sti_tdata),
    .sti_TKEEP  (sti_tkeep),
    .sti_TLAST  (sti_tlast),
    .sti_TVALID (sti_tvalid),
    .sti_TREADY (sti_tready),
    .sto_TDATA  (sto_tdata),
    .sto_TKEEP  (sto_tkeep),
    .sto_TLAST  (sto_tlast),
    .sto_TVALID (sto_tvalid),
    .sto_TREADY (sto_tready),
    .lvl        (lvl)
  );

  always #5 aclk = ~aclk;

  function automatic int n_last();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i][WW-1]) n++;
    return n;
  endfunction

  function automatic bit exp_valid();
    if (exp_q.size() == 0) return 1'b0;
`ifdef AXI4_STREAM_FIFO_PKT_EN
    return (n_last() != 0) || (exp_q.size() == DEPTH) || m_cut;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit exp_ready();
    return m_rdy && (exp_q.size() != DEPTH);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_rdy = 1'b0;
    m_cut = 1'b0;
  endtask

  task automatic model_edge();
    bit wr;
    bit rd;
    bit full_nopkt;
    logic [WW-1:0] w;
    if (clr) begin
      exp_q.delete();
      m_cut = 1'b0;
    end else begin
      wr = sti_tvalid && exp_ready();
      rd = sto_tready && exp_valid();
      full_nopkt = (exp_q.size() == DEPTH) && (n_last() == 0);
      if (rd) begin
        w = exp_q.pop_front();
        if (w[WW-1]) m_cut = 1'b0;
        else if (full_nopkt) m_cut = 1'b1;
      end else if (full_nopkt) begin
        m_cut = 1'b1;
      end
      if (wr) exp_q.push_back({sti_tlast, sti_tkeep, sti_tdata});
    end
    m_rdy = 1'b1;
  endtask

  // One clock: model follows the edge, then we land on the falling edge to sample and drive.
  task automatic tick();
    @(posedge aclk);
    model_edge();
    @(negedge aclk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    model_reset();
    repeat (2) @(negedge aclk);
    checks++; if (sti_tready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", sti_tready); end
    checks++; if (sto_tvalid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", sto_tvalid); end
    checks++; if (lvl !== CW'(0)) begin failures++; $display("FAIL rst_lvl got=%0d exp=0", lvl); end
    aresetn = 1'b1;
    tick();
    checks++; if (sti_tready !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b exp=1", sti_tready); end
    checks++; if (sto_tvalid !== 1'b0) begin failures++; $display("FAIL rel_valid got=%b exp=0", sto_tvalid); end
    checks++; if (lvl !== CW'(0)) begin failures++; $display("FAIL rel_lvl got=%0d exp=0", lvl); end
  endtask

  task automatic test_fill_drain();
    sto_tready = 1'b0;
    sti_tkeep  = '1;
    for (int i = 1; i <= DEPTH; i++) begin
      sti_tvalid = 1'b1;
      sti_tdata  = DW'(i);
      sti_tlast  = (i == DEPTH);
      tick();
    end
    checks++; if (lvl !== CW'(DEPTH)) begin failures++; $display("FAIL full_lvl got=%0d exp=%0d", lvl, DEPTH); end
    checks++; if (sti_tready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", sti_tready); end
    sti_tdata = DW'(17);
    sti_tlast = 1'b0;
    tick();
    checks++; if (lvl !== CW'(DEPTH)) begin failures++; $display("FAIL held17_lvl got=%0d exp=%0d", lvl, DEPTH); end
    sti_tvalid = 1'b0;
    sto_tready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (sto_tvalid !== 1'b1 || sto_tdata !== DW'(i)) begin
        failures++; $display("FAIL drain_order got=%b/%h exp=1/%h", sto_tvalid, sto_tdata, DW'(i));
      end
      tick();
    end
    checks++; if (sto_tvalid !== 1'b0 || lvl !== CW'(0)) begin failures++; $display("FAIL drain_empty got=%b/%0d exp=0/0", sto_tvalid, lvl); end
    sto_tready = 1'b0;
  endtask

  task automatic test_stream();
    sti_tkeep  = '1;
    sti_tlast  = 1'b1;
    sti_tvalid = 1'b1;
    sto_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sti_tdata = DW'(16'h0100 + i);
      tick();
      checks++;
      if (lvl !== CW'(1) || sto_tvalid !== 1'b1 || sto_tdata !== DW'(16'h0100 + i)) begin
        failures++; $display("FAIL stream beat=%0d got=%0d/%b/%h exp=1/1/%h", i, lvl, sto_tvalid, sto_tdata, DW'(16'h0100 + i));
      end
    end
    sti_tvalid = 1'b0;
    tick();
    checks++; if (lvl !== CW'(0) || sto_tvalid !== 1'b0) begin failures++; $display("FAIL stream_end got=%0d/%b exp=0/0", lvl, sto_tvalid); end
    sto_tready = 1'b0;
  endtask

  task automatic test_clr();
    sto_tready = 1'b0;
    sti_tlast  = 1'b1;
    sti_tkeep  = '1;
    for (int i = 0; i < 5; i++) begin
      sti_tvalid = 1'b1;
      sti_tdata  = DW'(16'h0500 + i);
      tick();
    end
    checks++; if (lvl !== CW'(5)) begin failures++; $display("FAIL clr_pre_lvl got=%0d exp=5", lvl); end
    clr = 1'b1;
    sti_tdata  = DW'(16'h5555);
    sto_tready = 1'b1;
    tick();
    clr = 1'b0;
    sto_tready = 1'b0;
    checks++; if (lvl !== CW'(0)) begin failures++; $display("FAIL clr_lvl got=%0d exp=0", lvl); end
    checks++; if (sto_tvalid !== 1'b0) begin failures++; $display("FAIL clr_valid got=%b exp=0", sto_tvalid); end
    checks++; if (sti_tready !== 1'b1) begin failures++; $display("FAIL clr_ready got=%b exp=1", sti_tready); end
    sti_tdata = DW'(16'hABCD);
    tick();
    sti_tvalid = 1'b0;
    checks++;
    if (sto_tvalid !== 1'b1 || sto_tdata !== DW'(16'hABCD) || lvl !== CW'(1)) begin
      failures++; $display("FAIL clr_first got=%b/%h/%0d exp=1/abcd/1", sto_tvalid, sto_tdata, lvl);
    end
    sto_tready = 1'b1;
    tick();
    sto_tready = 1'b0;
    checks++; if (lvl !== CW'(0)) begin failures++; $display("FAIL clr_post_lvl got=%0d exp=0", lvl); end
  endtask

`ifdef AXI4_STREAM_FIFO_PKT_EN
  task automatic test_pkt();
    int nb;
    bit acc;
    bit done;
    sto_tready = 1'b0;
    sti_tkeep  = '1;
    for (int i = 1; i <= 3; i++) begin
      sti_tvalid = 1'b1;
      sti_tdata  = DW'(16'h0300 + i);
      sti_tlast  = (i == 3);
      tick();
      checks++;
      if (sto_tvalid !== (i == 3) || lvl !== CW'(i)) begin
        failures++; $display("FAIL pkt_gate beat=%0d got=%b/%0d exp=%b/%0d", i, sto_tvalid, lvl, (i == 3), i);
      end
    end
    sti_tvalid = 1'b0;
    sto_tready = 1'b1;
    repeat (3) tick();
    checks++; if (lvl !== CW'(0) || sto_tvalid !== 1'b0) begin failures++; $display("FAIL pkt_drain got=%0d/%b exp=0/0", lvl, sto_tvalid); end
    sto_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sti_tvalid = 1'b1;
      sti_tdata  = DW'(16'h2000 + i);
      sti_tlast  = 1'b0;
      tick();
    end
    checks++; if (lvl !== CW'(DEPTH) || sto_tvalid !== 1'b1) begin failures++; $display("FAIL big_full got=%0d/%b exp=%0d/1", lvl, sto_tvalid, DEPTH); end
    sti_tdata = DW'(16'h2000 + DEPTH);
    tick();
    nb = DEPTH;
    sto_tready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      sti_tvalid = (nb < 20);
      sti_tdata  = DW'(16'h2000 + nb);
      sti_tlast  = (nb == 19);
      checks++;
      if (sto_tvalid !== (exp_q.size() != 0)) begin
        failures++; $display("FAIL big_cut c=%0d got=%b exp=%b", c, sto_tvalid, (exp_q.size() != 0));
      end else if (sto_tvalid && {sto_tlast, sto_tkeep, sto_tdata} !== exp_q[0]) begin
        failures++; $display("FAIL big_data c=%0d got=%h exp=%h", c, {sto_tlast, sto_tkeep, sto_tdata}, exp_q[0]);
      end
      acc = sti_tvalid && exp_ready();
      tick();
      if (acc) nb++;
      done = (nb == 20) && (exp_q.size() == 0);
    end
    sti_tvalid = 1'b0;
    checks++; if (!done || lvl !== CW'(0)) begin failures++; $display("FAIL big_done got=%0d/%0d exp=20/0", nb, lvl); end
    sto_tready = 1'b0;
    sti_tvalid = 1'b1;
    sti_tlast  = 1'b0;
    sti_tdata  = DW'(16'h3333);
    tick();
    sti_tvalid = 1'b0;
    checks++; if (sto_tvalid !== 1'b0 || lvl !== CW'(1)) begin failures++; $display("FAIL cut_clear got=%b/%0d exp=0/1", sto_tvalid, lvl); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask
`endif

  task automatic test_random();
    bit ok;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (lvl !== CW'(exp_q.size()) || sti_tready !== exp_ready() || sto_tvalid !== exp_valid()) begin
        failures++; $display("FAIL rand_ctl c=%0d got=%0d/%b/%b exp=%0d/%b/%b", c, lvl, sti_tready, sto_tvalid, exp_q.size(), exp_ready(), exp_valid());
      end
      if (exp_valid()) begin
        checks++;
        if ({sto_tlast, sto_tkeep, sto_tdata} !== exp_q[0]) begin
          failures++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, {sto_tlast, sto_tkeep, sto_tdata}, exp_q[0]);
        end
      end
      sti_tvalid = ($urandom_range(0, 9) < 7);
      sto_tready = ($urandom_range(0, 9) < 6);
      sti_tdata  = DW'($urandom);
      sti_tkeep  = DN'($urandom_range(0, (1 << DN) - 1));
      sti_tlast  = ($urandom_range(0, 5) == 0);
      tick();
    end
    // Close any open packet, then drain everything.
    sto_tready = 1'b1;
    sti_tvalid = 1'b1;
    sti_tlast  = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 4 * DEPTH && !ok; c++) begin
      ok = exp_ready();
      tick();
    end
    sti_tvalid = 1'b0;
    for (int c = 0; c < 4 * DEPTH && exp_q.size() != 0; c++) tick();
    checks++; if (!ok || exp_q.size() != 0 || lvl !== CW'(0)) begin failures++; $display("FAIL rand_drain got=%0d exp=0", lvl); end
    sto_tready = 1'b0;
  endtask

  task automatic test_async_reset();
    sto_tready = 1'b0;
    sti_tkeep  = '1;
    sti_tlast  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sti_tvalid = 1'b1;
      sti_tdata  = DW'(16'h0700 + i);
      tick();
    end
    checks++; if (lvl !== CW'(7)) begin failures++; $display("FAIL ar_pre_lvl got=%0d exp=7", lvl); end
    #2 aresetn = 1'b0;
    model_reset();
    #1;
    checks++; if (sto_tvalid !== 1'b0 || lvl !== CW'(0)) begin failures++; $display("FAIL ar_now got=%b/%0d exp=0/0", sto_tvalid, lvl); end
    checks++; if (sti_tready !== 1'b0) begin failures++; $display("FAIL ar_ready got=%b exp=0", sti_tready); end
    sti_tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    checks++; if (sti_tready !== 1'b1 || lvl !== CW'(0)) begin failures++; $display("FAIL ar_rel got=%b/%0d exp=1/0", sti_tready, lvl); end
    sti_tvalid = 1'b1;
    sti_tdata  = DW'(16'h7777);
    tick();
    sti_tvalid = 1'b0;
    checks++;
    if (sto_tvalid !== 1'b1 || sto_tdata !== DW'(16'h7777) || lvl !== CW'(1)) begin
      failures++; $display("FAIL ar_resume got=%b/%h/%0d exp=1/7777/1", sto_tvalid, sto_tdata, lvl);
    end
    sto_tready = 1'b1;
    tick();
    sto_tready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_stream();
    test_clr();
`ifdef AXI4_STREAM_FIFO_PKT_EN
    test_pkt();
`endif
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
